// File: rtl/rgb_vga_out.sv
// VGA timing generator that paints the visible area with a per-frame latched colour.
// Optional build macro RGB_VGA_TEST_PATTERN_EN replaces the colour with 64-pixel bars.
module rgb_vga_out #(
    parameter int CLK_DIV   = 2,
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [2:0] rgb_in,
    output logic       hsync,
    output logic       vsync,
    output logic [2:0] rgb_out,
    output logic       video_on,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
    localparam logic [9:0] H_SYNC_ON  = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] H_SYNC_OFF = 10'(H_VISIBLE + H_FRONT + H_SYNC);

    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
    localparam logic [9:0] V_SYNC_ON  = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] V_SYNC_OFF = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [DIV_W-1:0] r_div_cnt;
    logic [9:0]       r_h;
    logic [9:0]       r_v;
    logic [2:0]       r_frame_rgb;
    logic             r_wrap_d;
    logic             r_hsync;
    logic             r_vsync;
    logic [2:0]       r_rgb_out;
    logic             r_video_on;
    logic             r_frame_start;

    logic             w_tick;
    logic             w_h_end;
    logic             w_v_end;
    logic             w_wrap;
    logic             w_video;
    logic             w_hsync_n;
    logic             w_vsync_n;
    logic [2:0]       w_pixel;

    // With CLK_DIV=1 the divider stays at 0, so tick is permanently high.
    assign w_tick  = (r_div_cnt == DIV_LAST);
    assign w_h_end = (r_h == H_LAST);
    assign w_v_end = (r_v == V_LAST);
    assign w_wrap  = w_tick && w_h_end && w_v_end;

    assign w_video   = (r_h < H_VIS) && (r_v < V_VIS);
    assign w_hsync_n = !((r_h >= H_SYNC_ON) && (r_h < H_SYNC_OFF));
    assign w_vsync_n = !((r_v >= V_SYNC_ON) && (r_v < V_SYNC_OFF));

`ifdef RGB_VGA_TEST_PATTERN_EN
    assign w_pixel = w_video ? r_h[8:6] : 3'b000;
`else
    assign w_pixel = w_video ? r_frame_rgb : 3'b000;
`endif

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_div_cnt <= '0;
        end else if (w_tick) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_h <= '0;
            r_v <= '0;
        end else if (w_tick) begin
            r_h <= w_h_end ? 10'd0 : r_h + 10'd1;
            if (w_h_end) begin
                r_v <= w_v_end ? 10'd0 : r_v + 10'd1;
            end
        end
    end

    // Colour is only sampled on the wrap edge so a frame is never torn.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_frame_rgb <= 3'b000;
        end else if (w_wrap) begin
            r_frame_rgb <= rgb_in;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_rgb_out     <= 3'b000;
            r_video_on    <= 1'b0;
            r_wrap_d      <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_hsync       <= w_hsync_n;
            r_vsync       <= w_vsync_n;
            r_rgb_out     <= w_pixel;
            r_video_on    <= w_video;
            r_wrap_d      <= w_wrap;
            r_frame_start <= r_wrap_d;
        end
    end

    assign pixel_x     = r_h;
    assign pixel_y     = r_v;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign rgb_out     = r_rgb_out;
    assign video_on    = r_video_on;
    assign frame_start = r_frame_start;

endmodule

// File: doc/rgb_vga_out.md
# rgb_vga_out

Downstream display stage for the 3-bit colour produced by the switch/button colour selector (`RGB_IN`). It generates 640x480@60 Hz VGA timing from the 50 MHz system clock and paints the whole visible area with the selected colour. The block forces black during blanking. It latches the colour only at frame boundaries, so a button press never tears a frame.

## Interface

Parameters:
- `CLK_DIV`, 2, system clocks per pixel (50 MHz to 25 MHz); must be ≥1.
- `H_VISIBLE`, 640, visible pixels per line.
- `H_FRONT`, 16, horizontal front porch (pixels).
- `H_SYNC`, 96, hsync width (pixels).
- `H_BACK`, 48, horizontal back porch (pixels).
- `V_VISIBLE`, 480, visible lines.
- `V_FRONT`, 10, vertical front porch (lines).
- `V_SYNC`, 2, vsync width (lines).
- `V_BACK`, 33, vertical back porch (lines).

Ports:
- `clk`, in, 1, system clock, rising edge.
- `clr`, in, 1, reset; asynchronous, active-low.
- `rgb_in`, in, 3, colour from the selector; synchronous to `clk`.
- `hsync`, out, 1, horizontal sync, active-low.
- `vsync`, out, 1, vertical sync, active-low.
- `rgb_out`, out, 3, pixel colour to the DAC/pins.
- `video_on`, out, 1, high while the pixel is in the visible area.
- `pixel_x`, out, 10, horizontal counter value.
- `pixel_y`, out, 10, vertical counter value.
- `frame_start`, out, 1, one-`clk` pulse when the counters wrap to (0,0).

## Operation

- **Divider:** `div_cnt` counts 0..CLK_DIV-1. `tick` is high when `div_cnt == CLK_DIV-1`.
- **Horizontal counter:** `h` counts 0..H_TOTAL-1 (H_TOTAL = sum of the H_* parameters = 800). It advances only on `tick` and wraps to 0.
- **Vertical counter:** `v` counts 0..V_TOTAL-1 (525). It advances on the `tick` where `h` wraps, and wraps to 0.
- **Counter outputs:** `pixel_x = h` and `pixel_y = v`, driven directly from the counter registers.
- **Frame colour:** `frame_rgb` loads `rgb_in` on the `tick` where both counters wrap to (0,0). It holds that value for the whole frame. Changes to `rgb_in` mid-frame are ignored until the next wrap.
- **Registered outputs:** all are decoded from the current (`h`,`v`) and update every `clk`:
  - `video_on = (h < H_VISIBLE) && (v < V_VISIBLE)`.
  - `hsync` is low for H_VISIBLE+H_FRONT ≤ h < H_VISIBLE+H_FRONT+H_SYNC, i.e. h in 656..751.
  - `vsync` is low for v in 490..491 (same rule with the V_* parameters).
  - `rgb_out = video_on ? frame_rgb : 3'b000`.
- **frame_start:** high for exactly one `clk`, on the cycle after the counters become (0,0).
- **Reset values** (`clr` low): `div_cnt`=0, `h`=0, `v`=0, `frame_rgb`=000, `hsync`=1, `vsync`=1, `rgb_out`=000, `video_on`=0, `frame_start`=0.
- **Reset mid-frame:** reset takes effect immediately, without waiting for `clk`. After release, timing restarts from (0,0), showing black until the first wrap.
- **Simultaneous events:** if `rgb_in` changes on the same `clk` as the wrap `tick`, the value sampled at that edge is latched.

## Timing

- **Clocks per line/frame (default parameters):** one pixel = CLK_DIV clocks, one line = 1600 `clk`, one frame = 840 000 `clk`.
- **Output latency:** `hsync`, `vsync`, `video_on` and `rgb_out` lag the counter values on `pixel_x`/`pixel_y` by exactly one `clk`, and are aligned with each other.
- **After reset release:** the first `tick` occurs on the CLK_DIV-th rising edge. `h` becomes 1 on that edge.
- **Colour latency:** a new `rgb_in` becomes visible at the first visible pixel of the next frame. Worst case is ≈1 frame + 1 `clk`.
- **Ideal CLK_DIV=1:** `tick` is held high constantly.

## Configuration

- **`RGB_VGA_TEST_PATTERN_EN`:**
  - Defined: within the visible area, `rgb_out = pixel_x[8:6]`, giving 64-pixel colour bars 000,001,…,111 that repeat across the line. `frame_rgb` and `rgb_in` are ignored for the colour, but `frame_rgb` still latches. Blanking is still 000.
  - Undefined: normal `frame_rgb` behaviour.

## Test plan

1. **Reset:** assert `clr`=0 mid-line (h≈300, v≈100). Outputs immediately read hsync=1, vsync=1, rgb_out=000, video_on=0, pixel_x=pixel_y=0, before any `clk` edge.
2. **hsync:** period = 1600 `clk`. Low width = 192 `clk`. Falling edge occurs one `clk` after pixel_x becomes 656.
3. **vsync:** period = 840 000 `clk`. Low width = 3200 `clk`, while pixel_y = 490..491. `frame_start` pulses exactly once per period.
4. **Colour latching:** set rgb_in=101 at v=200. rgb_out keeps the old colour for the rest of the frame. After the next `frame_start`, rgb_out=101 on every visible pixel and 000 while video_on=0.
5. **Boundaries:** pixel (639,479) shows `frame_rgb`. Pixels (640,y) and (x,480) show 000. `h` wraps 799→0 and `v` wraps 524→0.
6. **Test pattern:** with `RGB_VGA_TEST_PATTERN_EN` defined, pixel_x 0..63 gives 000, 64..127 gives 001, 448..511 gives 111, and 512..575 gives 000 regardless of `rgb_in`.
